// File: rtl/icb_slave_buffer.sv
// -----------------------------------------------------------------------------
// icb_slave_buffer
// ICB slave front-end. Accepted ICB commands are queued in a first-word-fall-
// through command FIFO whose head drives the downstream request port. Every
// issued request records its read/write type in a tag FIFO. Each downstream
// completion pops one tag and pushes a response (read data zeroed for writes)
// into an in-order response FIFO, whose head drives the ICB response channel.
// An outstanding counter caps accepted-but-unanswered commands at
// MAX_OUTSTANDING. The response FIFO is the same size, so downstream
// completions never need back-pressure.
//
// Ports
//   clk, rst                      clock, asynchronous active-high reset
//   icb_cmd_*                     ICB command channel (slave side)
//   icb_rsp_*                     ICB response channel (slave side)
//   dn_req_*                      downstream request, head of command FIFO
//   dn_rsp_valid/rdata/err        downstream completion pulse, no ready
//   proto_err                     sticky: completion was unexpected or overflowed
// -----------------------------------------------------------------------------
module icb_slave_buffer #(
   parameter int AW              = 32,
   parameter int DW              = 32,
   parameter int CMD_DEPTH       = 4,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            icb_cmd_valid,
   output logic            icb_cmd_ready,
   input  logic [AW-1:0]   icb_cmd_addr,
   input  logic            icb_cmd_read,
   input  logic [DW-1:0]   icb_cmd_wdata,
   input  logic [DW/8-1:0] icb_cmd_wmask,
   output logic            icb_rsp_valid,
   input  logic            icb_rsp_ready,
   output logic [DW-1:0]   icb_rsp_rdata,
   output logic            icb_rsp_err,
   output logic            dn_req_valid,
   input  logic            dn_req_ready,
   output logic [AW-1:0]   dn_req_addr,
   output logic            dn_req_read,
   output logic [DW-1:0]   dn_req_wdata,
   output logic [DW/8-1:0] dn_req_wmask,
   input  logic            dn_rsp_valid,
   input  logic [DW-1:0]   dn_rsp_rdata,
   input  logic            dn_rsp_err,
   output logic            proto_err
);

   localparam int MW  = DW / 8;
   localparam int CW  = AW + 1 + DW + MW;
   localparam int RW  = DW + 1;
   localparam int CPW = $clog2(CMD_DEPTH);
   localparam int OPW = $clog2(MAX_OUTSTANDING);
   localparam int OCW = OPW + 1;
   localparam logic [CPW:0]   CMD_FULL_CNT = (CPW+1)'(CMD_DEPTH);
   localparam logic [OCW-1:0] OUT_MAX      = OCW'(MAX_OUTSTANDING);

   // Tag and response pointers wrap explicitly so MAX_OUTSTANDING need not be a power of two.
   function automatic logic [OPW-1:0] optr_inc(input logic [OPW-1:0] p);
      if (p == OPW'(MAX_OUTSTANDING - 1)) begin
         optr_inc = {OPW{1'b0}};
      end else begin
         optr_inc = p + OPW'(1);
      end
   endfunction

   logic [CW-1:0]              cmd_mem_q [CMD_DEPTH];
   logic [CW-1:0]              cmd_mem_d [CMD_DEPTH];
   logic [CPW-1:0]             cmd_wr_ptr_q, cmd_wr_ptr_d, cmd_rd_ptr_q, cmd_rd_ptr_d;
   logic [CPW:0]               cmd_cnt_q, cmd_cnt_d;
   logic [MAX_OUTSTANDING-1:0] tag_mem_q, tag_mem_d;
   logic [OPW-1:0]             tag_wr_ptr_q, tag_wr_ptr_d, tag_rd_ptr_q, tag_rd_ptr_d;
   logic [OCW-1:0]             tag_cnt_q, tag_cnt_d;
   logic [RW-1:0]              rsp_mem_q [MAX_OUTSTANDING];
   logic [RW-1:0]              rsp_mem_d [MAX_OUTSTANDING];
   logic [OPW-1:0]             rsp_wr_ptr_q, rsp_wr_ptr_d, rsp_rd_ptr_q, rsp_rd_ptr_d;
   logic [OCW-1:0]             rsp_cnt_q, rsp_cnt_d;
   logic [OCW-1:0]             out_cnt_q, out_cnt_d;
   logic                       ready_en_q, ready_en_d;
   logic                       proto_err_q, proto_err_d;

   logic cmd_empty_s, cmd_full_s, tag_empty_s, rsp_empty_s, rsp_full_s;
   logic cmd_hs_s, dn_hs_s, rsp_hs_s, rsp_push_s, tag_head_s;

   assign cmd_empty_s = (cmd_cnt_q == {(CPW+1){1'b0}});
   assign cmd_full_s  = (cmd_cnt_q == CMD_FULL_CNT);
   assign tag_empty_s = (tag_cnt_q == {OCW{1'b0}});
   assign rsp_empty_s = (rsp_cnt_q == {OCW{1'b0}});
   assign rsp_full_s  = (rsp_cnt_q == OUT_MAX);

   // Ready depends on registered state only, never on icb_cmd_valid.
   assign icb_cmd_ready = ready_en_q && !cmd_full_s && (out_cnt_q < OUT_MAX);
   assign dn_req_valid  = !cmd_empty_s;
   assign icb_rsp_valid = !rsp_empty_s;
   assign proto_err     = proto_err_q;

   assign {dn_req_addr, dn_req_read, dn_req_wdata, dn_req_wmask} = cmd_mem_q[cmd_rd_ptr_q];
   assign {icb_rsp_rdata, icb_rsp_err}                           = rsp_mem_q[rsp_rd_ptr_q];

   assign cmd_hs_s   = icb_cmd_valid && icb_cmd_ready;
   assign dn_hs_s    = dn_req_valid && dn_req_ready;
   assign rsp_hs_s   = icb_rsp_valid && icb_rsp_ready;
   assign tag_head_s = tag_mem_q[tag_rd_ptr_q];
   // A completion is only accepted when it matches an issued request and has room.
   assign rsp_push_s = dn_rsp_valid && !tag_empty_s && !rsp_full_s;

   // Command FIFO next state: push on ICB handshake, pop on downstream handshake.
   always_comb begin
      cmd_mem_d    = cmd_mem_q;
      cmd_wr_ptr_d = cmd_wr_ptr_q;
      cmd_rd_ptr_d = cmd_rd_ptr_q;
      cmd_cnt_d    = cmd_cnt_q;
      if (cmd_hs_s) begin
         cmd_mem_d[cmd_wr_ptr_q] = {icb_cmd_addr, icb_cmd_read, icb_cmd_wdata, icb_cmd_wmask};
         cmd_wr_ptr_d            = cmd_wr_ptr_q + CPW'(1);
      end else begin
         cmd_wr_ptr_d = cmd_wr_ptr_q;
      end
      if (dn_hs_s) begin
         cmd_rd_ptr_d = cmd_rd_ptr_q + CPW'(1);
      end else begin
         cmd_rd_ptr_d = cmd_rd_ptr_q;
      end
      case ({cmd_hs_s, dn_hs_s})
         2'b10:   cmd_cnt_d = cmd_cnt_q + (CPW+1)'(1);
         2'b01:   cmd_cnt_d = cmd_cnt_q - (CPW+1)'(1);
         default: cmd_cnt_d = cmd_cnt_q;
      endcase
   end

   // Tag FIFO next state: remembers read/write of each issued request in order.
   always_comb begin
      tag_mem_d    = tag_mem_q;
      tag_wr_ptr_d = tag_wr_ptr_q;
      tag_rd_ptr_d = tag_rd_ptr_q;
      tag_cnt_d    = tag_cnt_q;
      if (dn_hs_s) begin
         tag_mem_d[tag_wr_ptr_q] = dn_req_read;
         tag_wr_ptr_d            = optr_inc(tag_wr_ptr_q);
      end else begin
         tag_wr_ptr_d = tag_wr_ptr_q;
      end
      if (rsp_push_s) begin
         tag_rd_ptr_d = optr_inc(tag_rd_ptr_q);
      end else begin
         tag_rd_ptr_d = tag_rd_ptr_q;
      end
      case ({dn_hs_s, rsp_push_s})
         2'b10:   tag_cnt_d = tag_cnt_q + OCW'(1);
         2'b01:   tag_cnt_d = tag_cnt_q - OCW'(1);
         default: tag_cnt_d = tag_cnt_q;
      endcase
   end

   // Response FIFO next state: write responses carry zero read data.
   always_comb begin
      rsp_mem_d    = rsp_mem_q;
      rsp_wr_ptr_d = rsp_wr_ptr_q;
      rsp_rd_ptr_d = rsp_rd_ptr_q;
      rsp_cnt_d    = rsp_cnt_q;
      if (rsp_push_s) begin
         rsp_mem_d[rsp_wr_ptr_q] = {(tag_head_s ? dn_rsp_rdata : {DW{1'b0}}), dn_rsp_err};
         rsp_wr_ptr_d            = optr_inc(rsp_wr_ptr_q);
      end else begin
         rsp_wr_ptr_d = rsp_wr_ptr_q;
      end
      if (rsp_hs_s) begin
         rsp_rd_ptr_d = optr_inc(rsp_rd_ptr_q);
      end else begin
         rsp_rd_ptr_d = rsp_rd_ptr_q;
      end
      case ({rsp_push_s, rsp_hs_s})
         2'b10:   rsp_cnt_d = rsp_cnt_q + OCW'(1);
         2'b01:   rsp_cnt_d = rsp_cnt_q - OCW'(1);
         default: rsp_cnt_d = rsp_cnt_q;
      endcase
   end

   // Outstanding counter, ready enable and sticky protocol error.
   always_comb begin
      ready_en_d  = 1'b1;
      proto_err_d = proto_err_q | (dn_rsp_valid & ~rsp_push_s);
      case ({cmd_hs_s, rsp_hs_s})
         2'b10:   out_cnt_d = out_cnt_q + OCW'(1);
         2'b01:   out_cnt_d = out_cnt_q - OCW'(1);
         default: out_cnt_d = out_cnt_q;
      endcase
   end

   // State registers; reset clears storage so payload outputs read as zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < CMD_DEPTH; i++) begin
            cmd_mem_q[i] <= {CW{1'b0}};
         end
         for (int i = 0; i < MAX_OUTSTANDING; i++) begin
            rsp_mem_q[i] <= {RW{1'b0}};
         end
         cmd_wr_ptr_q <= {CPW{1'b0}};
         cmd_rd_ptr_q <= {CPW{1'b0}};
         cmd_cnt_q    <= {(CPW+1){1'b0}};
         tag_mem_q    <= {MAX_OUTSTANDING{1'b0}};
         tag_wr_ptr_q <= {OPW{1'b0}};
         tag_rd_ptr_q <= {OPW{1'b0}};
         tag_cnt_q    <= {OCW{1'b0}};
         rsp_wr_ptr_q <= {OPW{1'b0}};
         rsp_rd_ptr_q <= {OPW{1'b0}};
         rsp_cnt_q    <= {OCW{1'b0}};
         out_cnt_q    <= {OCW{1'b0}};
         ready_en_q   <= 1'b0;
         proto_err_q  <= 1'b0;
      end else begin
         cmd_mem_q    <= cmd_mem_d;
         rsp_mem_q    <= rsp_mem_d;
         cmd_wr_ptr_q <= cmd_wr_ptr_d;
         cmd_rd_ptr_q <= cmd_rd_ptr_d;
         cmd_cnt_q    <= cmd_cnt_d;
         tag_mem_q    <= tag_mem_d;
         tag_wr_ptr_q <= tag_wr_ptr_d;
         tag_rd_ptr_q <= tag_rd_ptr_d;
         tag_cnt_q    <= tag_cnt_d;
         rsp_wr_ptr_q <= rsp_wr_ptr_d;
         rsp_rd_ptr_q <= rsp_rd_ptr_d;
         rsp_cnt_q    <= rsp_cnt_d;
         out_cnt_q    <= out_cnt_d;
         ready_en_q   <= ready_en_d;
         proto_err_q  <= proto_err_d;
      end
   end

endmodule
